// File: rtl/mmio_rx_fifo.sv
// ---------------------------------------------------------------------------
// mmio_rx_fifo
//
// Receive FIFO between a host-side push interface and a core reading through
// memory-mapped registers. The FIFO is first-word-fall-through: the oldest
// entry sits on rd_data whenever rd_valid is high. The core removes it by
// pulsing rd_pop.
//
// Parameters
//   WIDTH  data width of one entry (default 8)
//   DEPTH  number of entries (default 8). It must be a power of two and at
//          least 2.
//
// Ports
//   clk           sole clock; all state changes on the rising edge
//   rst_n         synchronous reset, ACTIVE-HIGH despite its name (1 = reset)
//   host_wr_en    host push strobe, one entry per cycle
//   host_wr_data  host push data
//   host_full     FIFO holds DEPTH entries; pushes are dropped
//   rd_data       head entry (MMIO rd data register, 0x00)
//   rd_valid      head entry valid (MMIO rd valid, 0x01)
//   rd_pop        core consumed the head entry (ignored while rd_valid = 0)
//   overflow      a push was attempted while full
//   ovf_clr       clears the sticky overflow flag (sticky build only)
//   count         current occupancy, 0..DEPTH
//
// Handshake
//   A push is accepted when host_wr_en = 1 and host_full = 0. A pop takes
//   effect when rd_pop = 1 and rd_valid = 1. Both are qualified only by
//   registered flags, so no output depends combinationally on an input.
//
// Configuration macro
//   MMIO_RX_OVF_STICKY_EN  When this macro is defined, overflow is sticky.
//                          It is set the cycle after a dropped push and is
//                          held until ovf_clr or reset. If ovf_clr and a drop
//                          happen in the same cycle, the set wins.
//                          When the macro is undefined, overflow is a
//                          one-cycle pulse after each dropped push, and
//                          ovf_clr is ignored.
// ---------------------------------------------------------------------------
module mmio_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_wr_en,
    input  logic [WIDTH-1:0]         host_wr_data,
    output logic                     host_full,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_pop,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    logic push_ok;
    logic pop_ok;
    logic drop;

    // The flags come only from the registered occupancy.
    assign host_full = (count_r == CW'(DEPTH));
    assign rd_valid  = (count_r != '0);
    assign count     = count_r;
    assign overflow  = overflow_r;

    // The head is read straight from storage at the registered read pointer.
    // This gives fall-through behaviour. rd_data does not change until rd_ptr
    // moves, which only happens on an accepted pop.
    assign rd_data = mem[rd_ptr];

    // A full FIFO rejects a push even if a pop happens in the same cycle.
    // Using the pre-edge full flag keeps the acceptance decision free of any
    // path from rd_pop.
    assign push_ok = host_wr_en && !host_full;
    assign pop_ok  = rd_pop && rd_valid;
    assign drop    = host_wr_en && host_full;

    // Storage has no reset. A write during reset is blocked so the
    // same-cycle push is discarded along with the control state.
    always_ff @(posedge clk) begin
        if (!rst_n && push_ok) begin
            mem[wr_ptr] <= host_wr_data;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally and there is no bubble at the wrap point.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef MMIO_RX_OVF_STICKY_EN
    // Sticky flag. In a cycle with both a drop and ovf_clr, the set wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end
`else
    // One-cycle pulse per dropped push. ovf_clr has no effect in this build.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= drop;
        end
    end

    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_mmio_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_mmio_rx_fifo
//
// Self-checking bench for mmio_rx_fifo. The reference model is a queue of
// stored bytes plus an expected overflow bit. Data leaving through a pop is
// pushed onto exp_q by the driver. A separate monitor pops exp_q whenever the
// DUT shows rd_valid with rd_pop and compares the value against rd_data.
// Inputs are driven 1 time unit after the rising edge. The monitor samples on
// the falling edge. State checks run 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mmio_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             host_wr_en;
    logic [WIDTH-1:0] host_wr_data;
    logic             host_full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_pop;
    logic             overflow;
    logic             ovf_clr;
    logic [CW-1:0]    count;

    mmio_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_wr_en   (host_wr_en),
        .host_wr_data (host_wr_data),
        .host_full    (host_full),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_pop       (rd_pop),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .count        (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf;
    int               n_checks;
    int               n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(model_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(model_q.size() > 0));
        chk("host_full", 32'(host_full), 32'(model_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (model_q.size() > 0) begin
            chk("rd_data_head", 32'(rd_data), 32'(model_q[0]));
        end
    endtask

    // One clock cycle of stimulus. The model applies the FIFO rules to the
    // occupancy seen before the edge.
    task automatic step(input logic we, input logic [WIDTH-1:0] wd,
                        input logic pop, input logic clr);
        int   sz;
        logic dropped;
        sz           = model_q.size();
        host_wr_en   = we;
        host_wr_data = wd;
        rd_pop       = pop;
        ovf_clr      = clr;
        dropped      = we && (sz == DEPTH);
        if (pop && sz > 0) begin
            exp_q.push_back(model_q.pop_front());
        end
        if (we && sz < DEPTH) begin
            model_q.push_back(wd);
        end
`ifdef MMIO_RX_OVF_STICKY_EN
        if (dropped) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
`else
        exp_ovf = dropped;
`endif
        @(posedge clk);
        #1;
        host_wr_en = 1'b0;
        rd_pop     = 1'b0;
        ovf_clr    = 1'b0;
        check_state();
    endtask

    task automatic do_reset(input logic with_traffic);
        rst_n        = 1'b1;
        host_wr_en   = with_traffic;
        host_wr_data = 8'h77;
        rd_pop       = with_traffic;
        ovf_clr      = 1'b0;
        model_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        host_wr_en = 1'b0;
        rd_pop     = 1'b0;
        check_state();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_d;
        if (rst_n === 1'b0 && rd_valid === 1'b1 && rd_pop === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: pop seen with no expected entry, rd_data=%0h at %0t", rd_data, $time);
            end else begin
                exp_d = exp_q.pop_front();
                chk("pop_data", 32'(rd_data), 32'(exp_d));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        exp_ovf      = 1'b0;
        rst_n        = 1'b1;
        host_wr_en   = 1'b0;
        host_wr_data = '0;
        rd_pop       = 1'b0;
        ovf_clr      = 1'b0;

        // Reset state
        do_reset(1'b0);

        // Fill with 0x11..0x18, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h11 + i), 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'(8));
        chk("fill_full", 32'(host_full), 32'(1));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_valid", 32'(rd_valid), 32'(0));
        chk("drain_count", 32'(count), 32'(0));

        // Overflow: push 0xAA with pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h21 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("ovf_count7", 32'(count), 32'(7));
        chk("ovf_set", 32'(overflow), 32'(1));
        step(1'b0, '0, 1'b0, 1'b0);             // sticky holds, pulse clears
        step(1'b0, '0, 1'b0, 1'b1);             // clear request
        step(1'b1, 8'hBB, 1'b0, 1'b0);          // full again
        step(1'b1, 8'hCC, 1'b0, 1'b1);          // drop coincides with clear
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("no_aa_left", 32'(rd_valid), 32'(0));

        // Empty edge: push with pop from empty, then two lone pops
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        chk("empty_push_count", 32'(count), 32'(1));
        chk("empty_push_data", 32'(rd_data), 32'(8'h5C));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("empty_pop_count", 32'(count), 32'(0));

        // Wrap-around: sustained push+pop at count=3
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 32'(3));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-operation with a same-cycle push
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0);
        do_reset(1'b1);
        chk("midrst_count", 32'(count), 32'(0));
        chk("midrst_valid", 32'(rd_valid), 32'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);          // normal operation resumes

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 99) < 55, WIDTH'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < 45, $urandom_range(0, 9) == 0);
            end
        end

        // Drain and confirm the scoreboard saw every expected pop
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
